// File: rtl/vdcm_ssm_pkg.sv
// Shared types for the substream demux/scheduler: word width, SSM index type and FSM states.
package vdcm_ssm_pkg;
  localparam int WORD_W  = 128;
  localparam int MAX_SSM = 4;

  typedef logic [$clog2(MAX_SSM)-1:0] ssm_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;
endpackage

// File: rtl/ssm_word_fifo.sv
// Show-ahead word buffer for one substream; head is 0 whenever the buffer is empty.
module ssm_word_fifo #(
  parameter int WORD_W = 128,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WORD_W-1:0]            push_data,
  input  logic                         pop,
  output logic [WORD_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_W-1:0] mem   [DEPTH];
  logic [WORD_W-1:0] mem_n [DEPTH];
  logic [CW-1:0]     cnt_n;

  // Shift-down storage: vacated slots are zeroed so mem[0] reads 0 when empty.
  always_comb begin
    mem_n = mem;
    cnt_n = count;
    if (pop && (count != '0)) begin
      for (int i = 0; i < DEPTH-1; i++) mem_n[i] = mem[i+1];
      mem_n[DEPTH-1] = '0;
      cnt_n = count - CW'(1);
    end
    if (push && (cnt_n != CW'(DEPTH))) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_n == CW'(i)) mem_n[i] = push_data;
      end
      cnt_n = cnt_n + CW'(1);
    end
    if (flush) begin
      cnt_n = '0;
      for (int i = 0; i < DEPTH; i++) mem_n[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= cnt_n;
      mem   <= mem_n;
    end
  end

  assign head = mem[0];
endmodule

// File: rtl/ssm_demux_sched.sv
// Substream demux/scheduler: refills per-SSM word buffers in consumption order.
// Optional statistics counters are enabled with the SSM_DEMUX_STATS_EN macro.
module ssm_demux_sched #(
  parameter int NUM_SSM   = 4,
  parameter int BUF_DEPTH = 2,
  parameter int WORD_W    = vdcm_ssm_pkg::WORD_W
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start_dec,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic [NUM_SSM-1:0]          ssm_req,
  output logic [NUM_SSM*WORD_W-1:0]   ssm_data,
  output logic [NUM_SSM-1:0]          ssm_avail,
  output logic                        init_done,
  output logic [NUM_SSM-1:0]          err_underflow,
  output logic [1:0]                  state_dbg
`ifdef SSM_DEMUX_STATS_EN
  ,
  output logic [NUM_SSM*32-1:0]       stat_words,
  output logic [31:0]                 stat_stall_cyc
`endif
);
  import vdcm_ssm_pkg::*;

  localparam int QD  = NUM_SSM * BUF_DEPTH;
  localparam int QCW = $clog2(QD + 1);
  localparam int BCW = $clog2(BUF_DEPTH + 1);

  state_t          state, state_n;
  ssm_idx_t        q   [QD];
  ssm_idx_t        q_n [QD];
  logic [QCW-1:0]  q_cnt, q_cnt_n, init_cnt;
  ssm_idx_t        init_idx;
  logic            flush, accept, init_push, init_last, q_overflow;
  logic [NUM_SSM:0]   push_vec;
  logic [NUM_SSM-1:0] buf_empty, buf_push, buf_pop;
  logic [BCW-1:0]     buf_cnt [NUM_SSM];

  // Input handshake: a word transfers on a cycle where in_valid and in_ready are both high;
  // in_ready never depends on in_valid, and the word lands in buffer[q head] next cycle.
  assign flush     = !start_dec;
  assign in_ready  = ((state == FILL) || (state == RUN)) && (q_cnt != '0);
  assign accept    = in_valid && in_ready;
  assign init_push = (state == INIT);
  assign init_last = (init_cnt == QCW'(QD-1));
  assign init_done = (state == RUN);
  assign state_dbg = state;
  assign push_vec  = {buf_pop, init_push};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_dec) state_n = INIT;
      INIT:    if (init_last) state_n = FILL;
      FILL:    if (q_cnt_n == '0) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = IDLE;
    endcase
    if (!start_dec) state_n = IDLE;
  end

  // Order queue: one pop (accepted word) then up to NUM_SSM+1 appends in ascending source order.
  always_comb begin
    q_n        = q;
    q_cnt_n    = q_cnt;
    q_overflow = 1'b0;
    if (accept) begin
      for (int i = 0; i < QD-1; i++) q_n[i] = q[i+1];
      q_cnt_n = q_cnt - QCW'(1);
    end
    for (int p = 0; p <= NUM_SSM; p++) begin
      if (push_vec[p]) begin
        if (q_cnt_n == QCW'(QD)) begin
          q_overflow = 1'b1;
        end else begin
          for (int i = 0; i < QD; i++) begin
            if (q_cnt_n == QCW'(i)) q_n[i] = (p == 0) ? init_idx : ssm_idx_t'(p-1);
          end
          q_cnt_n = q_cnt_n + QCW'(1);
        end
      end
    end
    if (flush) q_cnt_n = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      q_cnt         <= '0;
      init_cnt      <= '0;
      init_idx      <= '0;
      err_underflow <= '0;
      for (int i = 0; i < QD; i++) q[i] <= '0;
    end else begin
      state         <= state_n;
      q             <= q_n;
      q_cnt         <= q_cnt_n;
      err_underflow <= err_underflow | (ssm_req & buf_empty);
      if ((state == INIT) && !flush) begin
        init_cnt <= init_cnt + QCW'(1);
        init_idx <= (init_idx == ssm_idx_t'(NUM_SSM-1)) ? '0 : init_idx + ssm_idx_t'(1);
      end else begin
        init_cnt <= '0;
        init_idx <= '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_SSM; k++) begin : g_buf
    assign buf_push[k]  = accept && (q[0] == ssm_idx_t'(k));
    assign buf_pop[k]   = (state == RUN) && ssm_req[k] && !buf_empty[k];
    assign buf_empty[k] = (buf_cnt[k] == '0);
    assign ssm_avail[k] = !buf_empty[k];

    ssm_word_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .push      (buf_push[k]),
      .push_data (in_data),
      .pop       (buf_pop[k]),
      .head      (ssm_data[k*WORD_W +: WORD_W]),
      .count     (buf_cnt[k])
    );
  end

`ifdef SSM_DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_words     <= '0;
      stat_stall_cyc <= '0;
    end else if (state_n == IDLE) begin
      stat_words     <= '0;
      stat_stall_cyc <= '0;
    end else begin
      for (int k = 0; k < NUM_SSM; k++) begin
        if (buf_pop[k] && (stat_words[k*32 +: 32] != 32'hFFFF_FFFF))
          stat_words[k*32 +: 32] <= stat_words[k*32 +: 32] + 32'd1;
      end
      if ((state == RUN) && (q_cnt != '0) && !in_valid && (stat_stall_cyc != 32'hFFFF_FFFF))
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) assert (!q_overflow);
  end
`endif
endmodule

// File: tb/tb_ssm_demux_sched.sv
// Bench for ssm_demux_sched (NUM_SSM=4, BUF_DEPTH=2) with a reference demux scoreboard.
module tb_ssm_demux_sched;
  localparam int M_IDLE = 0;
  localparam int M_INIT = 1;
  localparam int M_FILL = 2;
  localparam int M_RUN  = 3;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start_dec;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   ssm_req;
  logic [511:0] ssm_data;
  logic [3:0]   ssm_avail;
  logic         init_done;
  logic [3:0]   err_underflow;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [127:0] exp_q [4][$];
  int           ord_q [$];
  int           m_st = M_IDLE;
  int           m_init = 0;
  logic [3:0]   m_err = '0;
  int unsigned  word_ctr = 0;
  int unsigned  base;
  int           n;
  logic [3:0]   r;

  ssm_demux_sched #(.NUM_SSM(4), .BUF_DEPTH(2), .WORD_W(128)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_dec     (start_dec),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .ssm_req       (ssm_req),
    .ssm_data      (ssm_data),
    .ssm_avail     (ssm_avail),
    .init_done     (init_done),
    .err_underflow (err_underflow),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_word(input int unsigned v);
    return {v, ~v, v ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + v};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model, release ssm_req.
  task automatic cycle();
    logic [127:0] exp_d;
    logic         exp_rdy;
    logic [3:0]   uf;
    int           h;
    @(negedge clk);
    exp_rdy = ((m_st == M_FILL) || (m_st == M_RUN)) && (ord_q.size() != 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("init_done", init_done, m_st == M_RUN);
    chk("err_underflow", err_underflow, m_err);
    for (int k = 0; k < 4; k++) begin
      exp_d = (exp_q[k].size() != 0) ? exp_q[k][0] : '0;
      chk($sformatf("ssm_data%0d", k), ssm_data[k*128 +: 128], exp_d);
      chk($sformatf("ssm_avail%0d", k), ssm_avail[k], exp_q[k].size() != 0);
    end
    uf = '0;
    for (int k = 0; k < 4; k++) if (ssm_req[k] && (exp_q[k].size() == 0)) uf[k] = 1'b1;
    m_err = m_err | uf;
    if (!start_dec) begin
      m_st = M_IDLE;
      ord_q.delete();
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else if (m_st == M_IDLE) begin
      m_st = M_INIT;
      m_init = 0;
    end else if (m_st == M_INIT) begin
      ord_q.push_back(m_init % 4);
      m_init++;
      if (m_init == 8) m_st = M_FILL;
    end else begin
      if (m_st == M_RUN) begin
        for (int k = 0; k < 4; k++) begin
          if (ssm_req[k] && (exp_q[k].size() != 0)) begin
            void'(exp_q[k].pop_front());
            ord_q.push_back(k);
          end
        end
      end
      if (exp_rdy && in_valid) begin
        h = ord_q.pop_front();
        exp_q[h].push_back(in_data);
        word_ctr++;
      end
      if ((m_st == M_FILL) && (ord_q.size() == 0)) m_st = M_RUN;
    end
    @(posedge clk);
    #1;
    in_data = mk_word(word_ctr);
    ssm_req = '0;
  endtask

  initial begin
    rstn = 1'b0; start_dec = 1'b0; in_valid = 1'b0; ssm_req = '0;
    in_data = mk_word(0);
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_avail", ssm_avail, 4'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_err", err_underflow, 4'h0);
    chk("rst_data_lo", ssm_data[255:0], '0);
    chk("rst_data_hi", ssm_data[511:256], '0);
    chk("rst_state", state_dbg, 2'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // initial prefetch: W0..W7 round-robin
    start_dec = 1'b1; in_valid = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (init_done !== 1'b1 && n < 40);
    chk("init_latency", n, 17);
    for (int k = 0; k < 4; k++) chk($sformatf("init_head%0d", k), ssm_data[k*128 +: 128], mk_word(k));

    // refill order follows consumption order
    in_valid = 1'b0;
    ssm_req = 4'b0100; cycle();
    ssm_req = 4'b0001; cycle();
    in_valid = 1'b1; cycle(); cycle();
    in_valid = 1'b0;
    chk("order_ssm2_a", ssm_data[2*128 +: 128], mk_word(6));
    ssm_req = 4'b0100; cycle();
    chk("order_ssm2_b", ssm_data[2*128 +: 128], mk_word(8));
    chk("order_ssm0_a", ssm_data[0 +: 128], mk_word(4));
    ssm_req = 4'b0001; cycle();
    chk("order_ssm0_b", ssm_data[0 +: 128], mk_word(9));
    in_valid = 1'b1; cycle(); cycle();

    // simultaneous requests refill lowest index first
    in_valid = 1'b0;
    ssm_req = 4'b1011; cycle();
    in_valid = 1'b1; cycle(); cycle(); cycle();
    in_valid = 1'b0;
    ssm_req = 4'b1011; cycle();
    chk("tie_ssm0", ssm_data[0 +: 128], mk_word(12));
    chk("tie_ssm1", ssm_data[128 +: 128], mk_word(13));
    chk("tie_ssm3", ssm_data[3*128 +: 128], mk_word(14));
    in_valid = 1'b1; cycle(); cycle(); cycle();

    // underflow on ssm1
    in_valid = 1'b0;
    ssm_req = 4'b0010; cycle();
    ssm_req = 4'b0010; cycle();
    ssm_req = 4'b0010; cycle();
    chk("uf_flag", err_underflow, 4'b0010);
    chk("uf_data", ssm_data[128 +: 128], '0);
    in_valid = 1'b1; cycle(); cycle();
    chk("uf_owed_ready", in_ready, 1'b0);
    chk("uf_owed_data", ssm_data[128 +: 128], mk_word(18));
    in_valid = 1'b0;

    // flush and restart
    start_dec = 1'b0; cycle();
    chk("flush_avail", ssm_avail, 4'h0);
    chk("flush_ready", in_ready, 1'b0);
    chk("flush_init_done", init_done, 1'b0);
    chk("flush_err_held", err_underflow, 4'b0010);
    chk("flush_state", state_dbg, 2'd0);
    base = word_ctr;
    start_dec = 1'b1; in_valid = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (init_done !== 1'b1 && n < 40);
    chk("restart_latency", n, 17);
    chk("restart_ssm0", ssm_data[0 +: 128], mk_word(base));
    chk("restart_ssm1", ssm_data[128 +: 128], mk_word(base + 1));

    // random supply gaps with legal requests
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      r = '0;
      for (int k = 0; k < 4; k++) if ((exp_q[k].size() != 0) && ($urandom_range(0, 3) == 0)) r[k] = 1'b1;
      ssm_req = r;
      cycle();
    end
    chk("rand_no_new_uf", err_underflow, 4'b0010);

    // asynchronous reset mid-operation
    #3 rstn = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1'b0);
    chk("arst_avail", ssm_avail, 4'h0);
    chk("arst_init_done", init_done, 1'b0);
    chk("arst_err", err_underflow, 4'h0);
    chk("arst_data", ssm_data[127:0] | ssm_data[255:128] | ssm_data[383:256] | ssm_data[511:384], '0);
    chk("arst_state", state_dbg, 2'd0);
    m_st = M_IDLE; m_err = '0; ord_q.delete();
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (init_done !== 1'b1 && n < 40);
    chk("arst_restart_latency", n, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
